// File: rtl/cpu_pkg.sv
// Shared CPU definitions: machine width, fetch FSM states and the IF/ID record.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a zero-latency instruction memory,
// and holds the fetched word in an IF/ID register presented to decode.
//
// Handshake: out_valid_o/out_ready_i follow strict valid/ready rules. A word is
// transferred on a rising edge where both are high. While out_valid_o is high
// and out_ready_i is low, out_instr_o/out_pc_o are held stable. The only ways a
// presented word disappears without transfer are a redirect, a fault or reset.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [31:0]  imem_addr_o,
    input  logic [31:0]  imem_instr_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [31:0]  out_instr_o,
    output logic [31:0]  out_pc_o,
    output logic         fault_o,
    output logic [31:0]  fault_pc_o,
    output logic [31:0]  fetch_count_o,
    output fetch_state_e dbg_state_o
);

    // A misaligned reset vector is a build error, not something to recover from.
    generate
        if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
            $error("fetch_stage: RESET_PC must be 4-byte aligned");
        end
    endgenerate

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] count_q, count_d;

    logic slot_free;
    logic redirect_aligned;

    assign slot_free        = !valid_q || out_ready_i;
    assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);

    // Next-state logic: redirect beats fault beats fetch beats hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        valid_d    = valid_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;

        unique case (state_q)
            FETCH_RUN: begin
                if (redirect_valid_i) begin
                    // Either way the in-flight word belongs to the wrong path.
                    valid_d = 1'b0;
                    if (redirect_aligned) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        state_d    = FETCH_FAULT;
                        fault_pc_d = redirect_pc_i;
                    end
                end else if (slot_free) begin
                    if_id_d.instr = imem_instr_i;
                    if_id_d.pc    = pc_q;
                    valid_d       = 1'b1;
                    pc_d          = pc_q + XLEN'(INSTR_BYTES);
                    count_d       = count_q + 32'd1;
                end
            end
            FETCH_FAULT: begin
                // Parked until reset; nothing is presented to decode.
                valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH_FAULT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset wins over everything, including a pending fault.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FETCH_RUN;
            pc_q       <= RESET_PC;
            if_id_q    <= '0;
            valid_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            valid_q    <= valid_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign out_valid_o   = valid_q;
    assign out_instr_o   = if_id_q.instr;
    assign out_pc_o      = if_id_q.pc;
    assign fault_o       = (state_q == FETCH_FAULT);
    assign fault_pc_o    = fault_pc_q;
    assign fetch_count_o = count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a vector table for the main instance, a scoreboard of
// words decode is expected to accept, and a short wrap sequence on a second
// instance whose reset PC sits at the top of the address space.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h00A0_0113;
    localparam logic [31:0] W2 = 32'h0020_81B3;
    localparam logic [31:0] W3 = 32'h0000_006F;

    // ---------------- clock / reset ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- instruction memory ----------------
    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        mem[3] = W3;
    end

    // ---------------- DUT A (RESET_PC = 0) ----------------
    logic         rst_a, rv_a, rdy_a;
    logic [31:0]  rpc_a, addr_a, instr_a, opc_a, oinstr_a, fpc_a, cnt_a;
    logic         ovalid_a, fault_a;
    fetch_state_e st_a;

    assign instr_a = mem[addr_a[7:2]];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk_i(clk), .rst_i(rst_a),
        .imem_addr_o(addr_a), .imem_instr_i(instr_a),
        .redirect_valid_i(rv_a), .redirect_pc_i(rpc_a),
        .out_valid_o(ovalid_a), .out_ready_i(rdy_a),
        .out_instr_o(oinstr_a), .out_pc_o(opc_a),
        .fault_o(fault_a), .fault_pc_o(fpc_a),
        .fetch_count_o(cnt_a), .dbg_state_o(st_a)
    );

    // ---------------- DUT B (RESET_PC at the wrap point) ----------------
    logic         rst_b, rv_b, rdy_b;
    logic [31:0]  rpc_b, addr_b, instr_b, opc_b, oinstr_b, fpc_b, cnt_b;
    logic         ovalid_b, fault_b;
    fetch_state_e st_b;

    assign instr_b = mem[addr_b[7:2]];

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk_i(clk), .rst_i(rst_b),
        .imem_addr_o(addr_b), .imem_instr_i(instr_b),
        .redirect_valid_i(rv_b), .redirect_pc_i(rpc_b),
        .out_valid_o(ovalid_b), .out_ready_i(rdy_b),
        .out_instr_o(oinstr_b), .out_pc_o(opc_b),
        .fault_o(fault_b), .fault_pc_o(fpc_b),
        .fetch_count_o(cnt_b), .dbg_state_o(st_b)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called after inputs settle: a word with valid&&ready transfers on the next edge.
    task automatic monitor_handshake(input int idx);
        logic [63:0] e;
        if (ovalid_a && rdy_a) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL hs_extra v%0d: got pc=%h instr=%h want none", idx, opc_a, oinstr_a);
            end else begin
                e = exp_q.pop_front();
                if ({opc_a, oinstr_a} !== e) begin
                    bad++;
                    $display("FAIL hs_word v%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             idx, opc_a, oinstr_a, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk_data;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_fault;
        logic [31:0] e_fpc;
        logic [31:0] e_count;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
        input logic chk, input logic ev, input logic [31:0] epc, input logic [31:0] ein,
        input logic [31:0] ead, input logic ef, input logic [31:0] efp, input logic [31:0] ec);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.chk_data = chk; v.e_valid = ev; v.e_pc = epc; v.e_instr = ein;
        v.e_addr = ead; v.e_fault = ef; v.e_fpc = efp; v.e_count = ec;
        return v;
    endfunction

    vec_t vt [26];

    // Driver: apply one vector at the falling edge, check after the next rising edge.
    task automatic apply_vec(input int i);
        @(negedge clk);
        rst_a = vt[i].rst;
        rv_a  = vt[i].rv;
        rpc_a = vt[i].rpc;
        rdy_a = vt[i].rdy;
        #1;
        monitor_handshake(i);
        @(posedge clk);
        #1;
        check($sformatf("v%0d valid", i), 32'(ovalid_a), 32'(vt[i].e_valid));
        check($sformatf("v%0d addr", i), addr_a, vt[i].e_addr);
        check($sformatf("v%0d fault", i), 32'(fault_a), 32'(vt[i].e_fault));
        check($sformatf("v%0d fault_pc", i), fpc_a, vt[i].e_fpc);
        check($sformatf("v%0d count", i), cnt_a, vt[i].e_count);
        check($sformatf("v%0d state", i), 32'(st_a == FETCH_FAULT), 32'(vt[i].e_fault));
        if (vt[i].chk_data) begin
            check($sformatf("v%0d out_pc", i), opc_a, vt[i].e_pc);
            check($sformatf("v%0d out_instr", i), oinstr_a, vt[i].e_instr);
        end
    endtask

    initial begin
        rst_a = 1'b1; rv_a = 1'b0; rpc_a = '0; rdy_a = 1'b0;
        rst_b = 1'b1; rv_b = 1'b0; rpc_b = '0; rdy_b = 1'b1;

        //           rst rv rpc           rdy chk v  out_pc        out_instr           addr          f  fpc     count
        // reset, then streaming with ready high
        vt[0]  = mk(1, 0, 32'h0,  1, 1, 0, 32'h0,  32'h0,           32'h0,  0, 32'h0,  32'd0);
        vt[1]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h0,  W0,              32'h4,  0, 32'h0,  32'd1);
        vt[2]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);
        vt[3]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h8,  W2,              32'hC,  0, 32'h0,  32'd3);
        vt[4]  = mk(0, 0, 32'h0,  1, 1, 1, 32'hC,  W3,              32'h10, 0, 32'h0,  32'd4);
        // backpressure while pc 0x4 is presented
        vt[5]  = mk(1, 0, 32'h0,  0, 1, 0, 32'h0,  32'h0,           32'h0,  0, 32'h0,  32'd0);
        vt[6]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h0,  W0,              32'h4,  0, 32'h0,  32'd1);
        vt[7]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);
        vt[8]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);
        vt[9]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);
        vt[10] = mk(0, 0, 32'h0,  0, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);
        vt[11] = mk(0, 0, 32'h0,  1, 1, 1, 32'h8,  W2,              32'hC,  0, 32'h0,  32'd3);
        // aligned redirect while 0x8 is held: flush cycle, then 0x40
        vt[12] = mk(0, 1, 32'h40, 0, 0, 0, 32'h0,  32'h0,           32'h40, 0, 32'h0,  32'd3);
        vt[13] = mk(0, 0, 32'h0,  1, 1, 1, 32'h40, 32'hA000_0010,   32'h44, 0, 32'h0,  32'd4);
        vt[14] = mk(0, 0, 32'h0,  1, 1, 1, 32'h44, 32'hA000_0011,   32'h48, 0, 32'h0,  32'd5);
        vt[15] = mk(0, 1, 32'h10, 0, 0, 0, 32'h0,  32'h0,           32'h10, 0, 32'h0,  32'd5);
        vt[16] = mk(0, 0, 32'h0,  0, 1, 1, 32'h10, 32'hA000_0004,   32'h14, 0, 32'h0,  32'd6);
        vt[17] = mk(0, 0, 32'h0,  1, 1, 1, 32'h14, 32'hA000_0005,   32'h18, 0, 32'h0,  32'd7);
        // misaligned redirect: sticky fault, later redirect ignored, reset clears
        vt[18] = mk(0, 1, 32'h42, 0, 0, 0, 32'h0,  32'h0,           32'h18, 1, 32'h42, 32'd7);
        vt[19] = mk(0, 1, 32'h80, 1, 0, 0, 32'h0,  32'h0,           32'h18, 1, 32'h42, 32'd7);
        vt[20] = mk(0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h0,           32'h18, 1, 32'h42, 32'd7);
        vt[21] = mk(1, 0, 32'h0,  1, 1, 0, 32'h0,  32'h0,           32'h0,  0, 32'h0,  32'd0);
        vt[22] = mk(0, 0, 32'h0,  1, 1, 1, 32'h0,  W0,              32'h4,  0, 32'h0,  32'd1);
        // reset together with a redirect while a word is held
        vt[23] = mk(1, 1, 32'h40, 0, 1, 0, 32'h0,  32'h0,           32'h0,  0, 32'h0,  32'd0);
        vt[24] = mk(0, 0, 32'h0,  1, 1, 1, 32'h0,  W0,              32'h4,  0, 32'h0,  32'd1);
        vt[25] = mk(0, 0, 32'h0,  1, 1, 1, 32'h4,  W1,              32'h8,  0, 32'h0,  32'd2);

        // words decode should accept, in order; the held 0x8 word before the
        // redirect to 0x40 must never appear here
        exp_q.push_back({32'h0,  W0});
        exp_q.push_back({32'h4,  W1});
        exp_q.push_back({32'h8,  W2});
        exp_q.push_back({32'h0,  W0});
        exp_q.push_back({32'h4,  W1});
        exp_q.push_back({32'h40, 32'hA000_0010});
        exp_q.push_back({32'h10, 32'hA000_0004});
        exp_q.push_back({32'h0,  W0});

        for (int i = 0; i < 26; i++) apply_vec(i);

        // Wrap sequence on the second instance (held in reset until now).
        #1;
        check("wrap reset valid", 32'(ovalid_b), 32'h0);
        check("wrap reset addr", addr_b, 32'hFFFF_FFFC);
        check("wrap reset count", cnt_b, 32'h0);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("wrap first valid", 32'(ovalid_b), 32'h1);
        check("wrap first pc", opc_b, 32'hFFFF_FFFC);
        check("wrap first instr", oinstr_b, 32'hA000_003F);
        check("wrap first addr", addr_b, 32'h0);
        @(posedge clk);
        #1;
        check("wrap second pc", opc_b, 32'h0);
        check("wrap second instr", oinstr_b, W0);
        check("wrap second addr", addr_b, 32'h4);
        check("wrap second count", cnt_b, 32'd2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL hs_missing: got %0d words left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
